// File: rtl/dpram_b_reader.sv
// Port-B side of the J1 dual-port RAM mailbox: polls CTRL, streams LEN payload words, writes CTRL/STAT back.
// Optional DPRAM_PREFETCH_EN: a 2-entry prefetch FIFO replaces the serial fetch/wait/send loop.
module dpram_b_reader #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 8'h00,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 8'h01,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              b_en,
    output logic              b_we,
    output logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_din,
    input  logic [DATA_W-1:0] b_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    // Stream handshake: a beat transfers in any cycle with m_valid & m_ready; while
    // m_valid is high and m_ready low, m_data and m_last are held unchanged.
    typedef enum logic [2:0] {POLL_RD, POLL_CHK, FETCH, WAIT, SEND, CLR_WR, STAT_WR} state_t;

`ifdef DPRAM_PREFETCH_EN
    localparam state_t FIRST_ST = SEND;
`else
    localparam state_t FIRST_ST = FETCH;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d, count_q, count_d;
    logic              b_en_q, b_en_d, b_we_q, b_we_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [DATA_W-1:0] b_din_q, b_din_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] stat_word;
    logic              at_last;
    logic [ADDR_W-1:0] addr_inc;

    assign at_last  = (count_q == len_q - 8'd1);
    assign addr_inc = addr_q + ADDR_W'(1);

    always_comb begin
        stat_word       = '0;
        stat_word[15]   = 1'b1;
        stat_word[7:0]  = len_q;
    end

`ifdef DPRAM_PREFETCH_EN
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              pend_q, pend_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic              rd_issue, pop;
    logic [2:0]        in_use;

    // A read may issue when entries held plus the one in flight, less any leaving now, leave room.
    assign pop      = (state_q == SEND) && m_valid && m_ready;
    assign in_use   = {1'b0, occ_q} + {2'b00, pend_q};
    assign rd_issue = (state_q == SEND) && (rd_cnt_q != len_q) && (in_use < 3'd2 + {2'b00, pop});
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = fifo_q[rd_ptr_q];
    assign m_last   = m_valid && at_last;
    assign b_en     = b_en_q | rd_issue;
    assign b_addr   = rd_issue ? addr_q : b_addr_q;
`else
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign b_en    = b_en_q;
    assign b_addr  = b_addr_q;
`endif

    assign b_we  = b_we_q;
    assign b_din = b_din_q;
    assign busy  = busy_q;
    assign done  = done_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
`ifdef DPRAM_PREFETCH_EN
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pend_d   = rd_issue;
        rd_cnt_d = rd_cnt_q;
        if (pend_q) begin
            fifo_d[wr_ptr_q] = b_dout;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (pop) rd_ptr_d = !rd_ptr_q;
        occ_d = occ_q + {1'b0, pend_q} - {1'b0, pop};
        if (rd_issue) begin
            addr_d   = addr_inc;
            rd_cnt_d = rd_cnt_q + 8'd1;
        end
`else
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
`endif
        case (state_q)
            // Right after reset no CTRL read is outstanding yet, so issue one before checking.
            POLL_RD: if (b_en_q) state_d = POLL_CHK;
            POLL_CHK: begin
                if (b_dout[15]) begin
                    len_d   = b_dout[7:0];
                    count_d = '0;
                    addr_d  = BASE_ADDR;
`ifdef DPRAM_PREFETCH_EN
                    rd_cnt_d = '0;
`endif
                    state_d = (b_dout[7:0] == 8'd0) ? CLR_WR : FIRST_ST;
                end else begin
                    state_d = POLL_RD;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
`ifndef DPRAM_PREFETCH_EN
                m_data_d  = b_dout;
                m_valid_d = 1'b1;
                m_last_d  = at_last;
`endif
                state_d = SEND;
            end
            SEND: begin
`ifdef DPRAM_PREFETCH_EN
                if (pop) begin
                    count_d = count_q + 8'd1;
                    if (at_last) state_d = CLR_WR;
                end
`else
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    addr_d    = addr_inc;
                    count_d   = count_q + 8'd1;
                    state_d   = m_last_q ? CLR_WR : FETCH;
                end
`endif
            end
            CLR_WR:  state_d = STAT_WR;
            STAT_WR: state_d = POLL_RD;
            default: state_d = POLL_RD;
        endcase

        // RAM port and status outputs describe the state being entered.
        b_en_d   = 1'b0;
        b_we_d   = 1'b0;
        b_addr_d = b_addr_q;
        b_din_d  = '0;
        case (state_d)
            POLL_RD: begin
                b_en_d   = 1'b1;
                b_addr_d = CTRL_ADDR;
            end
            FETCH: begin
                b_en_d   = 1'b1;
                b_addr_d = addr_d;
            end
            CLR_WR: begin
                b_en_d   = 1'b1;
                b_we_d   = 1'b1;
                b_addr_d = CTRL_ADDR;
            end
            STAT_WR: begin
                b_en_d   = 1'b1;
                b_we_d   = 1'b1;
                b_addr_d = STAT_ADDR;
                b_din_d  = stat_word;
            end
            default: ;
        endcase
        busy_d = !(state_d inside {POLL_RD, POLL_CHK});
        done_d = (state_d == STAT_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= POLL_RD;
            addr_q   <= '0;
            len_q    <= '0;
            count_q  <= '0;
            b_en_q   <= 1'b0;
            b_we_q   <= 1'b0;
            b_addr_q <= '0;
            b_din_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DPRAM_PREFETCH_EN
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            occ_q     <= '0;
            pend_q    <= 1'b0;
            rd_cnt_q  <= '0;
`else
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            count_q  <= count_d;
            b_en_q   <= b_en_d;
            b_we_q   <= b_we_d;
            b_addr_q <= b_addr_d;
            b_din_q  <= b_din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DPRAM_PREFETCH_EN
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            pend_q   <= pend_d;
            rd_cnt_q <= rd_cnt_d;
`else
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_dpram_b_reader.sv
// Bench for dpram_b_reader: RAM model with a port A for the bench, a transfer-level
// expectation model (beats and write-backs), and a per-cycle compare process.
module tb_dpram_b_reader;

    localparam logic [7:0] CTRL_A = 8'h00;
    localparam logic [7:0] STAT_A = 8'h01;
    localparam logic [7:0] BASE_A = 8'h10;
`ifdef DPRAM_PREFETCH_EN
    localparam int BEAT_GAP = 1;
`else
    localparam int BEAT_GAP = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b_en, b_we, m_valid, m_last, busy, done;
    logic        m_ready = 1'b0;
    logic [7:0]  b_addr;
    logic [15:0] b_din, m_data;
    logic [15:0] b_dout = '0;

    logic        a_we = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [15:0] a_din = '0;
    logic [15:0] mem [256];
    logic [15:0] shadow [256];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cur_beats = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    bit xfer_active = 1'b0;
    bit after_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    logic [15:0] e_word;
    logic [23:0] w_ent;

    logic [15:0] exp_q[$];
    logic [23:0] exp_wr_q[$];
    logic [15:0] got_q[$];
    int          beat_cyc_q[$];

    dpram_b_reader #(
        .ADDR_W(8), .DATA_W(16),
        .CTRL_ADDR(CTRL_A), .STAT_ADDR(STAT_A), .BASE_ADDR(BASE_A)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port RAM, read-before-write, 1-cycle read latency on port B
    always @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_din;
        if (b_en) begin
            if (b_we) mem[b_addr] <= b_din;
            else      b_dout <= mem[b_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic port_a_write(input logic [7:0] addr, input logic [15:0] data);
        @(negedge clk);
        a_we = 1'b1;
        a_addr = addr;
        a_din = data;
        shadow[addr] = data;
        @(negedge clk);
        a_we = 1'b0;
    endtask

    // Transfer model: LEN words read from BASE upward modulo 256, CTRL still holding the
    // GO word while streaming; then CTRL<=0 and STAT<={1,7'b0,LEN}.
    task automatic build_expect(input int len);
        logic [15:0] ctrl_w;
        logic [7:0]  a;
        ctrl_w = 16'h8000 | 16'(len);
        exp_q.delete();
        exp_wr_q.delete();
        got_q.delete();
        beat_cyc_q.delete();
        for (int i = 0; i < len; i++) begin
            a = BASE_A + 8'(i);
            exp_q.push_back((a == CTRL_A) ? ctrl_w : shadow[a]);
        end
        exp_wr_q.push_back({CTRL_A, 16'h0000});
        exp_wr_q.push_back({STAT_A, ctrl_w});
        cur_beats = 0;
        stall_cnt = 0;
        xfer_active = 1'b1;
    endtask

    task automatic start_xfer(input int len);
        build_expect(len);
        port_a_write(CTRL_A, 16'h8000 | 16'(len));
    endtask

    task automatic wait_done(input int max_cyc);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check("xfer_done_in_time", done_cnt != start, 1);
        if (done_cnt == start) begin
            xfer_active = 1'b0;
            exp_q.delete();
            exp_wr_q.delete();
        end
        repeat (2) @(negedge clk);
        check("busy_idle", busy, 0);
        check("beats_left", exp_q.size(), 0);
        check("writes_left", exp_wr_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_b_en"}, b_en, 0);
        check({tag, "_b_we"}, b_we, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_b_din"}, b_din, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Downstream ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            2: m_ready = !(m_valid && cur_beats == 1 && stall_cnt < 5);
            3: m_ready = (cur_beats == 0);
            default: m_ready = 1'b0;
        endcase
    end

    // Scoreboard / per-cycle compare
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            after_done = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid) begin
                check("busy_with_valid", busy, 1);
                check("valid_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("m_last", m_last, exp_q.size() == 1);
            end
            if (m_valid && m_ready && exp_q.size() != 0) begin
                e_word = exp_q.pop_front();
                check("beat_data", m_data, e_word);
                got_q.push_back(m_data);
                beat_cyc_q.push_back(cyc);
                cur_beats++;
            end
            if (m_valid && !m_ready) stall_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (after_done) check("busy_after_done", busy, 0);
            after_done = 1'b0;
            if (b_en && b_we) begin
                check("wr_after_beats", exp_q.size(), 0);
                check("wr_pending", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) begin
                    w_ent = exp_wr_q.pop_front();
                    check("wr_addr", b_addr, w_ent[23:16]);
                    check("wr_data", b_din, w_ent[15:0]);
                    shadow[w_ent[23:16]] = w_ent[15:0];
                    check("done_with_stat", done, exp_wr_q.size() == 0);
                end
            end else begin
                check("done_idle", done, 0);
            end
            if (done) begin
                done_cnt++;
                after_done = 1'b1;
                check("busy_at_done", busy, 1);
                xfer_active = 1'b0;
            end else if (!xfer_active) begin
                check("idle_busy", busy, 0);
                check("idle_valid", m_valid, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        // RAM fill with the block held in reset
        for (int a = 0; a < 256; a++)
            port_a_write(8'(a), (a < 2) ? 16'h0000 : 16'($urandom_range(0, 65535)));
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        ready_mode = 0;

        // Three beats, free-flowing downstream
        port_a_write(8'h10, 16'h00A1);
        port_a_write(8'h11, 16'h00A2);
        port_a_write(8'h12, 16'h00A3);
        start_xfer(3);
        wait_done(200);
        check("t1_nbeats", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t1_beat0", got_q[0], 16'h00A1);
            check("t1_beat1", got_q[1], 16'h00A2);
            check("t1_beat2", got_q[2], 16'h00A3);
        end
        check("t1_ctrl", mem[0], 16'h0000);
        check("t1_stat", mem[1], 16'h8003);
        check("t1_done_pulses", done_cnt, 1);

        // Five-cycle backpressure on the second beat
        ready_mode = 2;
        start_xfer(3);
        wait_done(200);
        ready_mode = 0;
        check("t2_stall_cycles", stall_cnt, 5);
        check("t2_nbeats", got_q.size(), 3);
        if (got_q.size() == 3) check("t2_beat1", got_q[1], 16'h00A2);

        // Zero-length request
        start_xfer(0);
        wait_done(100);
        check("t3_nbeats", got_q.size(), 0);
        check("t3_stat", mem[1], 16'h8000);
        check("t3_done_pulses", done_cnt, 3);

        // Beat spacing with downstream always ready
        for (int i = 0; i < 4; i++) port_a_write(BASE_A + 8'(i), 16'($urandom_range(0, 65535)));
        start_xfer(4);
        wait_done(200);
        check("t6_nbeats", beat_cyc_q.size(), 4);
        for (int i = 1; i < beat_cyc_q.size(); i++)
            check("t6_beat_gap", beat_cyc_q[i] - beat_cyc_q[i-1], BEAT_GAP);

        // Reset while the second beat is waiting; transfer restarts from the base address
        port_a_write(8'h10, 16'h00A1);
        port_a_write(8'h11, 16'h00A2);
        port_a_write(8'h12, 16'h00A3);
        ready_mode = 3;
        start_xfer(3);
        n = 0;
        while (!(cur_beats == 1 && m_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_beat2", cur_beats == 1 && m_valid, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("t5_async");
        build_expect(3);
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_done(200);
        check("t5_nbeats", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t5_beat0", got_q[0], 16'h00A1);
            check("t5_beat2", got_q[2], 16'h00A3);
        end

        // Maximum length: reads wrap past 0xFF onto CTRL and STAT
        ready_mode = 1;
        start_xfer(255);
        wait_done(3000);
        check("t4_nbeats", got_q.size(), 255);
        if (got_q.size() == 255) begin
            check("t4_wrap_ctrl", got_q[240], 16'h80FF);
            check("t4_wrap_stat", got_q[241], 16'h8003);
        end
        check("t4_stat", mem[1], 16'h80FF);

        // Randomized transfers
        for (int t = 0; t < 10; t++) begin
            len = (t == 0) ? 1 : $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                port_a_write(BASE_A + 8'(i), 16'($urandom_range(0, 65535)));
            ready_mode = $urandom_range(0, 1);
            start_xfer(len);
            wait_done(400);
            check("rand_nbeats", got_q.size(), len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
